// File: rtl/io_responder.sv
// Memory-mapped I/O responder: display/LED registers, synchronized switches,
// debounced buttons with sticky rise flags, and a multiplexed 7-segment scanner.
module io_responder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] SCAN_DIV_RESET  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [9:0]  mem_addr,
  input  logic [31:0] write_mem_data,
  output logic [31:0] read_mem_data,
  input  logic [31:0] switch_in,
  input  logic [4:0]  button_in,
  output logic [31:0] display_C,
  output logic [31:0] led_C,
  output logic [4:0]  btn_db,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  logic [31:0] sw_s1, sw_s2;
  logic [4:0]  btn_s1, btn_s2;
  logic [15:0] db_cnt [5];
  logic [4:0]  btn_edge;
  logic [15:0] scan_div, scan_cnt;
  logic [2:0]  digit;

  logic        wr_display, wr_led, wr_edge, wr_div;
  logic [4:0]  db_hit, btn_rise, edge_clr;
  logic        scan_adv;
  logic [2:0]  digit_next;
  logic [31:0] display_next;
  logic [3:0]  nibble;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  always_comb begin
    wr_display = mem_write && (mem_addr == 10'h000);
    wr_led     = mem_write && (mem_addr == 10'h001);
    wr_edge    = mem_write && (mem_addr == 10'h004);
    wr_div     = mem_write && (mem_addr == 10'h005);
    edge_clr   = wr_edge ? write_mem_data[4:0] : 5'b0;
  end

  // A button toggles when it has disagreed with btn_db for DEBOUNCE_CYCLES edges.
  always_comb begin
    db_hit = '0;
    for (int i = 0; i < 5; i++)
      db_hit[i] = (btn_s2[i] != btn_db[i]) && (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1);
    btn_rise = db_hit & ~btn_db;
  end

  // Segment registers load from next-state values so they always match digit.
  always_comb begin
    scan_adv     = (scan_cnt >= scan_div);
    digit_next   = scan_adv ? digit + 3'd1 : digit;
    display_next = wr_display ? write_mem_data : display_C;
    nibble       = display_next[{digit_next, 2'b00} +: 4];
  end

  always_comb begin
    read_mem_data = 32'h0;
    case (mem_addr)
      10'h000: read_mem_data = display_C;
      10'h001: read_mem_data = led_C;
      10'h002: read_mem_data = sw_s2;
      10'h003: read_mem_data = {27'h0, btn_db};
      10'h004: read_mem_data = {27'h0, btn_edge};
      10'h005: read_mem_data = {16'h0, scan_div};
      default: read_mem_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      display_C <= 32'h0;
      led_C     <= 32'h0;
      scan_div  <= SCAN_DIV_RESET;
      btn_edge  <= 5'h0;
      btn_db    <= 5'h0;
      sw_s1     <= 32'h0;
      sw_s2     <= 32'h0;
      btn_s1    <= 5'h0;
      btn_s2    <= 5'h0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= 16'h0;
      scan_cnt  <= 16'h0;
      digit     <= 3'd0;
      seg_an    <= 8'hFE;
      seg_cat   <= 8'hC0;
    end else begin
      display_C <= display_next;
      if (wr_led) led_C <= write_mem_data;
      if (wr_div) scan_div <= write_mem_data[15:0];
      btn_edge  <= (btn_edge & ~edge_clr) | btn_rise;
      btn_db    <= btn_db ^ db_hit;
      sw_s1     <= switch_in;
      sw_s2     <= sw_s1;
      btn_s1    <= button_in;
      btn_s2    <= btn_s1;
      for (int i = 0; i < 5; i++) begin
        if ((btn_s2[i] == btn_db[i]) || db_hit[i]) db_cnt[i] <= 16'h0;
        else db_cnt[i] <= db_cnt[i] + 16'd1;
      end
      scan_cnt  <= scan_adv ? 16'h0 : scan_cnt + 16'd1;
      digit     <= digit_next;
      seg_an    <= ~(8'b1 << digit_next);
      seg_cat   <= hex7(nibble);
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: cycle model compared every negedge, plus literal
// expectations for scan order, debounce timing, edge flags, and reset.
module tb_io_responder;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic [9:0]  mem_addr = 10'h0;
  logic [31:0] write_mem_data = 32'h0;
  logic [31:0] read_mem_data;
  logic [31:0] switch_in = 32'h0;
  logic [4:0]  button_in = 5'h0;
  logic [31:0] display_C, led_C;
  logic [4:0]  btn_db;
  logic [7:0]  seg_an, seg_cat;

  io_responder #(.DEBOUNCE_CYCLES(16'd4), .SCAN_DIV_RESET(16'd2)) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_addr(mem_addr),
    .write_mem_data(write_mem_data), .read_mem_data(read_mem_data),
    .switch_in(switch_in), .button_in(button_in), .display_C(display_C),
    .led_C(led_C), .btn_db(btn_db), .seg_an(seg_an), .seg_cat(seg_cat));

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
  endtask

  // ---- behavioural model ----
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [31:0] m_disp, m_led, m_sw1, m_sw2;
  logic [15:0] m_sdiv;
  logic [4:0]  m_edge, m_db, m_b1, m_b2;
  int          m_run [5];
  int          m_cnt, m_idx;

  always @(posedge clk) begin
    logic [4:0]  clr, rise;
    logic [15:0] old_div;
    if (rst) begin
      m_disp = 0; m_led = 0; m_sw1 = 0; m_sw2 = 0; m_sdiv = 16'd2;
      m_edge = 0; m_db = 0; m_b1 = 0; m_b2 = 0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      m_cnt = 0; m_idx = 0;
    end else begin
      clr = 0; rise = 0; old_div = m_sdiv;
      if (mem_write) begin
        case (mem_addr)
          10'h000: m_disp = write_mem_data;
          10'h001: m_led = write_mem_data;
          10'h004: clr = write_mem_data[4:0];
          10'h005: m_sdiv = write_mem_data[15:0];
          default: ;
        endcase
      end
      // digit period is SCAN_DIV+1 edges
      if (m_cnt >= old_div) begin m_cnt = 0; m_idx = (m_idx + 1) % 8; end
      else m_cnt++;
      // a level must disagree for DEB consecutive edges to be accepted
      for (int i = 0; i < 5; i++) begin
        if (m_b2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_db[i] = ~m_db[i];
            rise[i] = m_db[i];
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
      m_edge = (m_edge & ~clr) | rise;
      m_sw2 = m_sw1; m_sw1 = switch_in;
      m_b2 = m_b1;   m_b1 = button_in;
    end
  end

  function automatic logic [31:0] model_read(input logic [9:0] a);
    case (a)
      10'h000: return m_disp;
      10'h001: return m_led;
      10'h002: return m_sw2;
      10'h003: return {27'h0, m_db};
      10'h004: return {27'h0, m_edge};
      10'h005: return {16'h0, m_sdiv};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [7:0] onehot;
    if (chk_en) begin
      onehot = 8'h01 << m_idx;
      check("display_C", display_C, m_disp);
      check("led_C", led_C, m_led);
      check("btn_db", {27'h0, btn_db}, {27'h0, m_db});
      check("seg_an", {24'h0, seg_an}, {24'h0, ~onehot});
      check("seg_cat", {24'h0, seg_cat}, {24'h0, hex_tab[(m_disp >> (4 * m_idx)) & 32'hF]});
      check("read_mem_data", read_mem_data, model_read(mem_addr));
    end
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d);
    mem_write = 1'b1; mem_addr = a; write_mem_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  initial begin
    int hits_fe, hits_7f;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset seg_an", {24'h0, seg_an}, 32'hFE);
    check("reset seg_cat", {24'h0, seg_cat}, 32'hC0);
    check("reset btn_db", {27'h0, btn_db}, 32'h0);
    mem_addr = 10'h005; #1;
    check("reset scan_div", read_mem_data, 32'h2);
    check("model scan_div", {16'h0, m_sdiv}, 32'h2);

    // scanning with SCAN_DIV=0: one digit per cycle
    store(10'h000, 32'h89ABCDEF);
    check("display written", display_C, 32'h89ABCDEF);
    store(10'h005, 32'h0);
    hits_fe = 0; hits_7f = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (seg_an == 8'hFE) begin hits_fe++; check("digit0 F", {24'h0, seg_cat}, 32'h8E); end
      if (seg_an == 8'h7F) begin hits_7f++; check("digit7 8", {24'h0, seg_cat}, 32'h80); end
    end
    check("digit0 seen twice", hits_fe, 32'd2);
    check("digit7 seen twice", hits_7f, 32'd2);

    // 3-cycle glitch is rejected
    button_in = 5'b00001;
    tick(); tick(); tick();
    button_in = 5'b00000;
    for (int k = 0; k < 8; k++) tick();
    check("glitch rejected", {27'h0, btn_db}, 32'h0);

    // held press: accepted exactly 2+4 edges after the rise
    button_in = 5'b00001;
    for (int k = 0; k < 5; k++) tick();
    check("db0 before 6", {27'h0, btn_db}, 32'h0);
    tick();
    check("db0 at 6", {27'h0, btn_db}, 32'h1);
    mem_addr = 10'h004; #1;
    check("btn_edge after press", read_mem_data, 32'h1);

    // clear of bit0 in the same edge as a bit1 rise
    button_in = 5'b00011;
    for (int k = 0; k < 5; k++) tick();
    check("db1 not yet", {27'h0, btn_db}, 32'h1);
    store(10'h004, 32'h1);
    mem_addr = 10'h004; #1;
    check("btn_edge set/clear", read_mem_data, 32'h2);
    check("db both", {27'h0, btn_db}, 32'h3);

    // switch sync latency, unmapped read, RO write ignored
    switch_in = 32'hDEADBEEF; mem_addr = 10'h002;
    tick(); tick();
    check("switch 2-cycle", read_mem_data, 32'hDEADBEEF);
    mem_addr = 10'h3FF; #1;
    check("unmapped read", read_mem_data, 32'h0);
    store(10'h002, 32'h0);
    mem_addr = 10'h002; #1;
    check("switch RO", read_mem_data, 32'hDEADBEEF);
    store(10'h001, 32'h12345678);
    check("led written", led_C, 32'h12345678);

    // reset mid-debounce, with a simultaneous LED store
    button_in = 5'b00000;
    for (int k = 0; k < 12; k++) tick();
    button_in = 5'b00100;
    tick(); tick(); tick();
    rst = 1'b1; mem_write = 1'b1; mem_addr = 10'h001; write_mem_data = 32'h5A;
    tick();
    rst = 1'b0; mem_write = 1'b0;
    check("rst beats store", led_C, 32'h0);
    check("rst clears db", {27'h0, btn_db}, 32'h0);
    check("rst seg_an", {24'h0, seg_an}, 32'hFE);
    for (int k = 0; k < 5; k++) tick();
    check("db2 restart early", {27'h0, btn_db}, 32'h0);
    tick();
    check("db2 restart at 6", {27'h0, btn_db}, 32'h4);
    tick(); tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
